// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// One transaction in flight: accept, one execute cycle, then a held response.
module alu_op_scheduler #(
  parameter int W   = 8,
  parameter int OPW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*W-1:0]   req_opA,
  input  logic [2*W-1:0]   req_opB,
  input  logic [2*OPW-1:0] req_op,
  output logic [W-1:0]     alu_opA,
  output logic [W-1:0]     alu_opB,
  output logic [OPW-1:0]   alu_op,
  input  logic [W-1:0]     alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [OPW-1:0] op_q, op_d;
  logic           id_q, id_d;
  logic [W-1:0]   res_q, res_d;
  logic           zero_q, zero_d;
  logic           grant;

  // Priority holder wins if valid, otherwise the other requester.
  assign grant = req_valid[prio_q] ? prio_q : ~prio_q;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_d      = op_q;
    id_d      = id_q;
    res_d     = res_q;
    zero_d    = zero_q;
    req_ready = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant ? 2'b10 : 2'b01;
          opa_d     = grant ? req_opA[2*W-1:W] : req_opA[W-1:0];
          opb_d     = grant ? req_opB[2*W-1:W] : req_opB[W-1:0];
          op_d      = grant ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
          id_d      = grant;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = (alu_result == '0);
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_opA    = opa_q;
  assign alu_opB    = opb_q;
  assign alu_op     = op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);

endmodule
